// File: rtl/branch_sched_pkg.sv
// Shared definitions for the ID-stage branch resolution scheduler.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   BR_* branch-type codes (same values as nPC_sel), state_e FSM states,
//   br_target() target adder, br_is_active()/br_needs_rt() type decoders.
package branch_sched_pkg;

   localparam logic [3:0] BR_NONE = 4'd0;
   localparam logic [3:0] BR_BEQ  = 4'd1;
   localparam logic [3:0] BR_BNE  = 4'd2;
   localparam logic [3:0] BR_BLEZ = 4'd3;
   localparam logic [3:0] BR_BGTZ = 4'd4;
   localparam logic [3:0] BR_BLTZ = 4'd5;
   localparam logic [3:0] BR_BGEZ = 4'd6;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   // Target of a taken branch: delay-slot PC plus word-scaled signed offset.
   // Wraps modulo 2^32 by construction of the 32-bit adder.
   function automatic logic [31:0] br_target(input logic [31:0] pc,
                                             input logic [15:0] offset);
      return pc + 32'd4 + {{14{offset[15]}}, offset, 2'b00};
   endfunction

   // Codes 7..15 are treated exactly like BR_NONE.
   function automatic logic br_is_active(input logic [3:0] br_type);
      return (br_type >= BR_BEQ) && (br_type <= BR_BGEZ);
   endfunction

   // Only the two-register compares look at rt.
   function automatic logic br_needs_rt(input logic [3:0] br_type);
      return (br_type == BR_BEQ) || (br_type == BR_BNE);
   endfunction

endpackage

// File: rtl/branch_sched_cond.sv
// Branch condition evaluator: decides taken/not-taken from rs, rt and type.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is used.
//
// Ports:
//   rs_val, rt_val  operand values (rt only used by beq/bne)
//   br_type         branch-type code, BR_NONE and unknown codes give 0
//   taken           condition result
module branch_cond
   import branch_sched_pkg::*;
(
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic [3:0]  br_type,
   output logic        taken
);

   logic rs_neg;
   logic rs_zero;
   logic rs_eq_rt;

   // Signed compares against zero reduce to the sign bit and a zero test.
   assign rs_neg   = rs_val[31];
   assign rs_zero  = (rs_val == 32'd0);
   assign rs_eq_rt = (rs_val == rt_val);

   always_comb begin
      taken = 1'b0;
      case (br_type)
         BR_BEQ:  taken = rs_eq_rt;
         BR_BNE:  taken = !rs_eq_rt;
         BR_BLEZ: taken = rs_neg || rs_zero;
         BR_BGTZ: taken = !rs_neg && !rs_zero;
         BR_BLTZ: taken = rs_neg;
         BR_BGEZ: taken = !rs_neg;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_sched.sv
// ID-stage branch scheduler: holds ID until operands arrive, resolves, redirects PC.
// Latency: zero-cycle resolve when operands are ready; statistics one cycle later.
// Backpressure: stall_id holds IF/ID while operands are pending or id_hold is set.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   id_valid, id_hold          ID instruction valid, downstream freeze
//   id_br_type                 branch-type code (see branch_sched_pkg)
//   id_rs_*/id_rt_*            forwarded operand ready flags and values
//   id_pc, id_offset           branch PC and immediate field
//   stall_id                   freeze IF/ID this cycle
//   pc_redirect/redirect_target  one-cycle PC load, target 0 when idle
//   br_total, br_taken         saturating statistics
//   err_timeout                sticky operand timeout flag
//
// MAX_WAIT must be at least 1.
module branch_sched
   import branch_sched_pkg::*;
#(
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic             id_hold,
   input  logic [3:0]       id_br_type,
   input  logic             id_rs_ready,
   input  logic             id_rt_ready,
   input  logic [31:0]      id_rs_val,
   input  logic [31:0]      id_rt_val,
   input  logic [31:0]      id_pc,
   input  logic [15:0]      id_offset,
   output logic             stall_id,
   output logic             pc_redirect,
   output logic [31:0]      redirect_target,
   output logic [CNT_W-1:0] br_total,
   output logic [CNT_W-1:0] br_taken,
   output logic             err_timeout
);

   localparam int WCNT_W = $clog2(MAX_WAIT + 1);

   state_e             state_q;
   logic [WCNT_W-1:0]  wait_cnt_q;
   logic [CNT_W-1:0]   br_total_q;
   logic [CNT_W-1:0]   br_taken_q;
   logic               err_q;

   logic               br_act;
   logic               br_rdy;
   logic               at_limit;
   logic               cond_taken;
   logic [31:0]        target;

   logic               resolve;
   logic               timeout;
   logic               stall;

   branch_cond u_cond (
      .rs_val  (id_rs_val),
      .rt_val  (id_rt_val),
      .br_type (id_br_type),
      .taken   (cond_taken)
   );

   assign target   = br_target(id_pc, id_offset);
   assign br_act   = id_valid && br_is_active(id_br_type);
   // id_hold makes an otherwise ready branch look not ready.
   assign br_rdy   = id_rs_ready && (id_rt_ready || !br_needs_rt(id_br_type)) && !id_hold;
   assign at_limit = (wait_cnt_q == WCNT_W'(MAX_WAIT));

   // Per-cycle decision. In WAIT, a branch that disappears is a flush:
   // none of resolve/timeout/stall fire, so nothing is counted.
   always_comb begin
      resolve = 1'b0;
      timeout = 1'b0;
      stall   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (br_act) begin
               if (br_rdy) resolve = 1'b1;
               else        stall   = 1'b1;
            end
         end
         ST_WAIT: begin
            if (br_act) begin
               if (br_rdy)        resolve = 1'b1;
               else if (at_limit) timeout = 1'b1;
               else               stall   = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // FSM, wait counter and statistics.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= '0;
         br_total_q <= '0;
         br_taken_q <= '0;
         err_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (stall) begin
                  state_q    <= ST_WAIT;
                  wait_cnt_q <= WCNT_W'(1);
               end
            end
            ST_WAIT: begin
               if (stall) begin
                  wait_cnt_q <= wait_cnt_q + WCNT_W'(1);
               end else begin
                  // resolve, timeout or flush all end the wait
                  state_q    <= ST_IDLE;
                  wait_cnt_q <= '0;
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               wait_cnt_q <= '0;
            end
         endcase

         // A timed-out branch counts as a (not-taken) branch.
         if ((resolve || timeout) && (br_total_q != {CNT_W{1'b1}})) begin
            br_total_q <= br_total_q + CNT_W'(1);
         end
         if (resolve && cond_taken && (br_taken_q != {CNT_W{1'b1}})) begin
            br_taken_q <= br_taken_q + CNT_W'(1);
         end
         if (timeout) begin
            err_q <= 1'b1;
         end
      end
   end

   // Combinational outputs are forced low while reset is asserted, so an
   // async reset in the middle of a wait drops stall/redirect immediately.
   assign stall_id        = rst_n && stall;
   assign pc_redirect     = rst_n && resolve && cond_taken;
   assign redirect_target = pc_redirect ? target : 32'd0;

   assign br_total        = br_total_q;
   assign br_taken        = br_taken_q;
   assign err_timeout     = err_q;

endmodule

// File: tb/tb_branch_sched.sv
// Self-checking bench for branch_sched: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the branch rules.
// Two instances share stimulus: CNT_W=16 and CNT_W=4 (saturation).
module tb_branch_sched;

   localparam int MAX_WAIT = 15;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid, id_hold, id_rs_ready, id_rt_ready;
   logic [3:0]  id_br_type;
   logic [31:0] id_rs_val, id_rt_val, id_pc;
   logic [15:0] id_offset;

   logic        stall_a, red_a, err_a;
   logic [31:0] tgt_a;
   logic [15:0] tot_a, tkn_a;
   logic        stall_b, red_b, err_b;
   logic [31:0] tgt_b;
   logic [3:0]  tot_b, tkn_b;

   always #5 clk = ~clk;

   branch_sched #(.MAX_WAIT(MAX_WAIT), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_hold(id_hold),
      .id_br_type(id_br_type), .id_rs_ready(id_rs_ready), .id_rt_ready(id_rt_ready),
      .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_pc(id_pc), .id_offset(id_offset),
      .stall_id(stall_a), .pc_redirect(red_a), .redirect_target(tgt_a),
      .br_total(tot_a), .br_taken(tkn_a), .err_timeout(err_a)
   );

   branch_sched #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_hold(id_hold),
      .id_br_type(id_br_type), .id_rs_ready(id_rs_ready), .id_rt_ready(id_rt_ready),
      .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_pc(id_pc), .id_offset(id_offset),
      .stall_id(stall_b), .pc_redirect(red_b), .redirect_target(tgt_b),
      .br_total(tot_b), .br_taken(tkn_b), .err_timeout(err_b)
   );

   int n_cmp = 0;
   int n_err = 0;

   // reference model state: stall cycles spent on the current branch
   int     m_pend;
   longint m_total, m_taken;
   bit     m_err;

   // expected values for the sampled cycle (counters are pre-update)
   bit          e_stall, e_red, e_err;
   logic [31:0] e_tgt;
   longint      e_tot, e_tkn;
   // observed values sampled at the falling edge
   logic        o_stall, o_red, o_err, o_stall_b, o_red_b;
   logic [31:0] o_tgt;
   logic [15:0] o_tot, o_tkn;
   logic [3:0]  o_tot_b, o_tkn_b;

   function automatic bit ref_taken(input logic [3:0] t, input logic [31:0] rs, input logic [31:0] rt);
      case (t)
         4'd1: return rs == rt;
         4'd2: return rs != rt;
         4'd3: return $signed(rs) <= 0;
         4'd4: return $signed(rs) > 0;
         4'd5: return $signed(rs) < 0;
         4'd6: return $signed(rs) >= 0;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [15:0] off);
      int so;
      so = int'($signed(off));
      return pc + 32'd4 + 32'(so * 4);
   endfunction

   function automatic longint sat(input longint v, input longint maxv);
      return (v > maxv) ? maxv : v;
   endfunction

   task automatic idle_inputs();
      id_valid = 1'b0; id_hold = 1'b0; id_br_type = 4'd0;
      id_rs_ready = 1'b0; id_rt_ready = 1'b0;
      id_rs_val = 32'd0; id_rt_val = 32'd0; id_pc = 32'd0; id_offset = 16'd0;
   endtask

   task automatic set_br(input logic [3:0] t, input logic rsr, input logic rtr,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] pc, input logic [15:0] off);
      id_valid = 1'b1; id_hold = 1'b0; id_br_type = t;
      id_rs_ready = rsr; id_rt_ready = rtr;
      id_rs_val = rs; id_rt_val = rt; id_pc = pc; id_offset = off;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      m_pend = 0; m_total = 0; m_taken = 0; m_err = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      #1;
   endtask

   // One clock cycle: sample DUT at the falling edge, compute the expected
   // outputs from the branch rules, advance the model, return after the edge.
   task automatic model_cycle();
      bit act, rdy, tk;
      @(negedge clk);
      act = id_valid && (id_br_type >= 4'd1) && (id_br_type <= 4'd6);
      rdy = id_rs_ready && ((id_br_type != 4'd1 && id_br_type != 4'd2) || id_rt_ready) && !id_hold;
      tk  = ref_taken(id_br_type, id_rs_val, id_rt_val);
      e_tot = m_total; e_tkn = m_taken; e_err = m_err;
      e_stall = 1'b0; e_red = 1'b0; e_tgt = 32'd0;
      if (!act) begin
         m_pend = 0;
      end else if (rdy) begin
         e_red = tk;
         if (tk) e_tgt = ref_target(id_pc, id_offset);
         m_total++;
         if (tk) m_taken++;
         m_pend = 0;
      end else if (m_pend == MAX_WAIT) begin
         m_total++;
         m_err = 1'b1;
         m_pend = 0;
      end else begin
         e_stall = 1'b1;
         m_pend++;
      end
      o_stall = stall_a; o_red = red_a; o_tgt = tgt_a; o_err = err_a;
      o_tot = tot_a; o_tkn = tkn_a; o_tot_b = tot_b; o_tkn_b = tkn_b;
      o_stall_b = stall_b; o_red_b = red_b;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      set_br(4'd1, 1'b1, 1'b1, 32'h55, 32'h55, 32'h100, 16'h1);
      @(negedge clk);
      if (stall_a !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", stall_a); end
      n_cmp++;
      if (red_a !== 1'b0) begin n_err++; $display("FAIL reset_redirect got %b want 0", red_a); end
      n_cmp++;
      if (tgt_a !== 32'd0) begin n_err++; $display("FAIL reset_target got %h want 0", tgt_a); end
      n_cmp++;
      if (tot_a !== 16'd0 || tkn_a !== 16'd0 || err_a !== 1'b0) begin
         n_err++; $display("FAIL reset_stats got tot=%0d tkn=%0d err=%b want 0/0/0", tot_a, tkn_a, err_a);
      end
      n_cmp++;
      do_reset();
   endtask

   task automatic test_beq_basic();
      set_br(4'd1, 1'b1, 1'b1, 32'h1234, 32'h1234, 32'h3000, 16'h0004);
      model_cycle();
      if (o_red !== 1'b1 || o_red !== e_red) begin n_err++; $display("FAIL beq_redirect got %b want 1", o_red); end
      n_cmp++;
      if (o_tgt !== 32'h3014 || o_tgt !== e_tgt) begin n_err++; $display("FAIL beq_target got %h want 00003014", o_tgt); end
      n_cmp++;
      if (o_stall !== 1'b0) begin n_err++; $display("FAIL beq_stall got %b want 0", o_stall); end
      n_cmp++;
      idle_inputs();
      model_cycle();
      if (o_tot !== 16'd1 || o_tkn !== 16'd1) begin
         n_err++; $display("FAIL beq_stats got tot=%0d tkn=%0d want 1/1", o_tot, o_tkn);
      end
      n_cmp++;
   endtask

   task automatic test_bne_stall();
      set_br(4'd2, 1'b1, 1'b0, 32'd5, 32'd0, 32'h4000, 16'h0010);
      for (int c = 0; c < 3; c++) begin
         if (c == 2) begin id_rt_ready = 1'b1; id_rt_val = 32'd7; end
         model_cycle();
         if (o_stall !== (c < 2) || o_stall !== e_stall) begin
            n_err++; $display("FAIL bne_stall c=%0d got %b want %b", c, o_stall, e_stall);
         end
         n_cmp++;
         if (o_red !== (c == 2) || o_red !== e_red) begin
            n_err++; $display("FAIL bne_redirect c=%0d got %b want %b", c, o_red, e_red);
         end
         n_cmp++;
      end
      if (o_tgt !== 32'h4044) begin n_err++; $display("FAIL bne_target got %h want 00004044", o_tgt); end
      n_cmp++;
      idle_inputs();
   endtask

   task automatic test_signed_types();
      logic [31:0] rsv [4];
      bit          exp_tk [4];
      logic [31:0] pc, want;
      rsv = '{32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'd0};
      exp_tk = '{1'b1, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 4; i++) begin
         pc = 32'h0004_0000 + 32'(i * 16);
         // rt is irrelevant for these types: leave it not ready
         set_br(4'(3 + i), 1'b1, 1'b0, rsv[i], 32'hDEAD, pc, 16'h8000);
         model_cycle();
         want = exp_tk[i] ? (pc + 32'd4 - 32'h0002_0000) : 32'd0;
         if (o_red !== exp_tk[i] || o_red !== e_red || o_stall !== 1'b0) begin
            n_err++; $display("FAIL signed_redirect type=%0d got %b stall=%b want %b", 3 + i, o_red, o_stall, exp_tk[i]);
         end
         n_cmp++;
         if (o_tgt !== want || o_tgt !== e_tgt) begin
            n_err++; $display("FAIL signed_target type=%0d got %h want %h", 3 + i, o_tgt, want);
         end
         n_cmp++;
      end
      idle_inputs();
   endtask

   task automatic test_hold();
      set_br(4'd1, 1'b1, 1'b1, 32'd9, 32'd9, 32'h800, 16'hFFFF);
      id_hold = 1'b1;
      model_cycle();
      if (o_stall !== 1'b1 || o_red !== 1'b0) begin
         n_err++; $display("FAIL hold_stall got stall=%b red=%b want 1/0", o_stall, o_red);
      end
      n_cmp++;
      id_hold = 1'b0;
      model_cycle();
      if (o_red !== 1'b1 || o_tgt !== 32'h800) begin
         n_err++; $display("FAIL hold_release got red=%b tgt=%h want 1/00000800", o_red, o_tgt);
      end
      n_cmp++;
      idle_inputs();
   endtask

   task automatic test_flush();
      longint tot0;
      tot0 = m_total;
      set_br(4'd1, 1'b1, 1'b0, 32'd1, 32'd1, 32'h900, 16'h1);
      repeat (3) model_cycle();
      id_valid = 1'b0;
      model_cycle();
      if (o_stall !== 1'b0 || o_red !== 1'b0) begin
         n_err++; $display("FAIL flush_outputs got stall=%b red=%b want 0/0", o_stall, o_red);
      end
      n_cmp++;
      idle_inputs();
      model_cycle();
      if (o_tot !== 16'(tot0)) begin n_err++; $display("FAIL flush_count got %0d want %0d", o_tot, tot0); end
      n_cmp++;
   endtask

   task automatic test_timeout();
      longint tot0, tkn0;
      int     n_stall;
      tot0 = m_total; tkn0 = m_taken; n_stall = 0;
      set_br(4'd6, 1'b0, 1'b1, 32'd3, 32'd3, 32'h1000, 16'h40);
      for (int c = 0; c < MAX_WAIT + 1; c++) begin
         model_cycle();
         if (o_stall === 1'b1) n_stall++;
         if (o_red !== 1'b0) begin n_err++; $display("FAIL timeout_redirect c=%0d got %b want 0", c, o_red); end
         n_cmp++;
      end
      if (n_stall != MAX_WAIT || o_stall !== 1'b0) begin
         n_err++; $display("FAIL timeout_stalls got %0d last=%b want %0d/0", n_stall, o_stall, MAX_WAIT);
      end
      n_cmp++;
      idle_inputs();
      model_cycle();
      if (o_err !== 1'b1 || o_err !== e_err) begin n_err++; $display("FAIL timeout_err got %b want 1", o_err); end
      n_cmp++;
      if (o_tkn !== 16'(tkn0) || o_tot !== 16'(tot0 + 1)) begin
         n_err++; $display("FAIL timeout_stats got tot=%0d tkn=%0d want %0d/%0d", o_tot, o_tkn, tot0 + 1, tkn0);
      end
      n_cmp++;
   endtask

   task automatic test_reset_mid_wait();
      set_br(4'd1, 1'b1, 1'b0, 32'd4, 32'd4, 32'h2000, 16'h2);
      repeat (3) model_cycle();
      @(negedge clk);
      if (stall_a !== 1'b1) begin n_err++; $display("FAIL midwait_prestall got %b want 1", stall_a); end
      n_cmp++;
      #2 rst_n = 1'b0;
      #1;
      if (stall_a !== 1'b0 || red_a !== 1'b0 || tgt_a !== 32'd0) begin
         n_err++; $display("FAIL midwait_outputs got stall=%b red=%b tgt=%h want 0", stall_a, red_a, tgt_a);
      end
      n_cmp++;
      if (tot_a !== 16'd0 || tkn_a !== 16'd0 || err_a !== 1'b0 || tot_b !== 4'd0) begin
         n_err++; $display("FAIL midwait_stats got tot=%0d tkn=%0d err=%b want 0", tot_a, tkn_a, err_a);
      end
      n_cmp++;
      do_reset();
      set_br(4'd1, 1'b1, 1'b1, 32'd4, 32'd4, 32'h2000, 16'h2);
      model_cycle();
      if (o_red !== 1'b1 || o_tgt !== 32'h200C || o_stall !== 1'b0) begin
         n_err++; $display("FAIL midwait_after got red=%b tgt=%h stall=%b want 1/0000200c/0", o_red, o_tgt, o_stall);
      end
      n_cmp++;
      idle_inputs();
   endtask

   task automatic test_random();
      logic [31:0] rs;
      for (int i = 0; i < 600; i++) begin
         id_valid    = ($urandom_range(0, 9) != 0);
         id_br_type  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 6));
         id_rs_ready = ($urandom_range(0, 9) < 6);
         id_rt_ready = ($urandom_range(0, 9) < 6);
         id_hold     = ($urandom_range(0, 9) == 0);
         case ($urandom_range(0, 4))
            0: rs = 32'd0;
            1: rs = 32'h8000_0000;
            2: rs = 32'hFFFF_FFFF;
            default: rs = $urandom;
         endcase
         id_rs_val = rs;
         id_rt_val = ($urandom_range(0, 1) == 0) ? rs : $urandom;
         id_pc     = $urandom;
         id_offset = 16'($urandom);
         model_cycle();
         if (o_stall !== e_stall || o_stall_b !== e_stall) begin
            n_err++; $display("FAIL rand_stall i=%0d got %b/%b want %b", i, o_stall, o_stall_b, e_stall);
         end
         n_cmp++;
         if (o_red !== e_red || o_red_b !== e_red) begin
            n_err++; $display("FAIL rand_redirect i=%0d got %b/%b want %b", i, o_red, o_red_b, e_red);
         end
         n_cmp++;
         if (o_tgt !== e_tgt) begin n_err++; $display("FAIL rand_target i=%0d got %h want %h", i, o_tgt, e_tgt); end
         n_cmp++;
         if (o_tot !== 16'(sat(e_tot, 65535)) || o_tkn !== 16'(sat(e_tkn, 65535))) begin
            n_err++; $display("FAIL rand_stats i=%0d got %0d/%0d want %0d/%0d", i, o_tot, o_tkn, e_tot, e_tkn);
         end
         n_cmp++;
         if (o_tot_b !== 4'(sat(e_tot, 15)) || o_tkn_b !== 4'(sat(e_tkn, 15))) begin
            n_err++; $display("FAIL rand_stats4 i=%0d got %0d/%0d want %0d/%0d", i, o_tot_b, o_tkn_b, sat(e_tot, 15), sat(e_tkn, 15));
         end
         n_cmp++;
         if (o_err !== e_err) begin n_err++; $display("FAIL rand_err i=%0d got %b want %b", i, o_err, e_err); end
         n_cmp++;
      end
      idle_inputs();
   endtask

   task automatic test_back_to_back_saturation();
      do_reset();
      for (int i = 0; i < 17; i++) begin
         set_br(4'd1, 1'b1, 1'b1, 32'(i), 32'(i), 32'(i * 8), 16'h3);
         model_cycle();
         if (o_red !== 1'b1 || o_stall !== 1'b0) begin
            n_err++; $display("FAIL b2b_redirect i=%0d got red=%b stall=%b want 1/0", i, o_red, o_stall);
         end
         n_cmp++;
      end
      idle_inputs();
      model_cycle();
      if (o_tot_b !== 4'd15 || o_tkn_b !== 4'd15) begin
         n_err++; $display("FAIL sat4_stats got tot=%0d tkn=%0d want 15/15", o_tot_b, o_tkn_b);
      end
      n_cmp++;
      if (o_tot !== 16'd17 || o_tkn !== 16'd17) begin
         n_err++; $display("FAIL sat16_stats got tot=%0d tkn=%0d want 17/17", o_tot, o_tkn);
      end
      n_cmp++;
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_beq_basic();
      test_bne_stall();
      test_signed_types();
      test_hold();
      test_flush();
      test_timeout();
      test_reset_mid_wait();
      test_random();
      test_back_to_back_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
